demux_stream: RTL and testbench

Registered one-to-N stream demultiplexer with valid/ready handshaking: the inverse of the generic mux. One producer stream carries a destination index with each beat, and the block delivers that beat to exactly one of NUM_OUTPUTS consumer lanes. Each lane has its own one-entry holding register, so a stalled lane never blocks traffic to other lanes once its beat is parked. It sits between shared producers (writeback, dispatch) and per-lane consumers in the GPGPU datapath.

---
 rtl/demux_pkg.sv | 31 +++
 rtl/demux_slot.sv | 84 ++++++++
 rtl/demux_stream.sv | 117 +++++++++++
 tb/tb_demux_stream.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the demux_stream block:
//   OOR_COUNT_WIDTH / OOR_COUNT_MAX : width and ceiling of the dropped-beat counter
//   slot_state_t                    : per-lane holding register occupancy
//   sat_inc()                       : saturating increment for the dropped-beat counter
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int OOR_COUNT_WIDTH = 16;
    localparam logic [OOR_COUNT_WIDTH-1:0] OOR_COUNT_MAX = 16'hFFFF;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Increment that sticks at the ceiling instead of wrapping to zero.
    function automatic logic [OOR_COUNT_WIDTH-1:0] sat_inc(
        input logic [OOR_COUNT_WIDTH-1:0] value
    );
        logic [OOR_COUNT_WIDTH-1:0] result;
        if (value == OOR_COUNT_MAX) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-entry register stage for a single output lane of demux_stream.
// A write into a FULL slot is only issued when the slot drains in the same
// cycle, so the newer beat simply replaces the one leaving.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_wr_en         : load i_wr_data into the slot this cycle
//   i_wr_data       : beat payload
//   i_rd_ready      : lane consumer accepts the parked beat
//   o_valid         : slot FULL
//   o_data          : parked payload (holds last written value when EMPTY)
//   o_can_accept    : slot can take a write this cycle (EMPTY or draining)
// -----------------------------------------------------------------------------
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_can_accept
);

    slot_state_t           r_state;
    slot_state_t           w_state_next;
    logic [DATA_WIDTH-1:0] r_data;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Occupancy next-state: a write always leaves the slot FULL.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_EMPTY: begin
                if (i_wr_en) begin
                    w_state_next = SLOT_FULL;
                end else begin
                    w_state_next = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (i_wr_en) begin
                    w_state_next = SLOT_FULL;
                end else if (i_rd_ready) begin
                    w_state_next = SLOT_EMPTY;
                end else begin
                    w_state_next = SLOT_FULL;
                end
            end
            default: begin
                w_state_next = SLOT_EMPTY;
            end
        endcase
    end

    // Payload register: only a write changes it, so it keeps the last beat after draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= {DATA_WIDTH{1'b0}};
        end else if (i_wr_en) begin
            r_data <= i_wr_data;
        end else begin
            r_data <= r_data;
        end
    end

    assign o_valid      = (r_state == SLOT_FULL);
    assign o_data       = r_data;
    assign o_can_accept = (r_state == SLOT_EMPTY) || i_rd_ready;

endmodule

// File: rtl/demux_stream.sv
// -----------------------------------------------------------------------------
// demux_stream
// Registered one-to-N valid/ready stream demultiplexer. Each accepted beat is
// parked in the holding register of the lane named by in_sel; lanes stall
// independently. Indices >= NUM_OUTPUTS are accepted and dropped, and counted
// in a saturating counter.
// Optional feature (macro DEMUX_BROADCAST_EN): adds in_bcast; a broadcast beat
// waits until every lane can accept and is then written to all lanes.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (flushes all lanes)
//   in_data    : beat payload
//   in_sel     : destination lane index
//   in_valid   : producer has a beat
//   in_ready   : beat accepted this cycle (combinational from in_sel, out_ready, state)
//   in_bcast   : broadcast request (DEMUX_BROADCAST_EN only)
//   out_data   : per-lane payload, unpacked array
//   out_valid  : per-lane beat present
//   out_ready  : per-lane consumer accepts
//   oor_count  : saturating count of dropped out-of-range beats
// -----------------------------------------------------------------------------
module demux_stream
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_OUTPUTS = 32,
    parameter int SEL_WIDTH   = $clog2(NUM_OUTPUTS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      in_data,
    input  logic [SEL_WIDTH-1:0]       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
`ifdef DEMUX_BROADCAST_EN
    input  logic                       in_bcast,
`endif
    output logic [DATA_WIDTH-1:0]      out_data [NUM_OUTPUTS],
    output logic [NUM_OUTPUTS-1:0]     out_valid,
    input  logic [NUM_OUTPUTS-1:0]     out_ready,
    output logic [OOR_COUNT_WIDTH-1:0] oor_count
);

    logic [NUM_OUTPUTS-1:0]     w_can_accept;
    logic [NUM_OUTPUTS-1:0]     w_wr_en;
    logic                       w_bcast;
    logic                       w_sel_in_range;
    logic                       w_sel_ready;
    logic                       w_all_ready;
    logic                       w_xfer;
    logic                       w_oor_xfer;
    logic [OOR_COUNT_WIDTH-1:0] r_oor_count;

`ifdef DEMUX_BROADCAST_EN
    assign w_bcast = in_bcast;
`else
    assign w_bcast = 1'b0;
`endif

    // Index can only exceed the lane count when NUM_OUTPUTS is not a power of two.
    assign w_sel_in_range = (32'(in_sel) < 32'(NUM_OUTPUTS));
    assign w_all_ready    = &w_can_accept;

    // Ready selection over the addressed lane; out-of-range beats are always taken.
    always_comb begin
        w_sel_ready = 1'b0;
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            w_sel_ready = w_sel_ready | ((in_sel == SEL_WIDTH'(k)) & w_can_accept[k]);
        end
        if (w_bcast) begin
            in_ready = w_all_ready;
        end else if (!w_sel_in_range) begin
            in_ready = 1'b1;
        end else begin
            in_ready = w_sel_ready;
        end
    end

    assign w_xfer     = in_valid && in_ready;
    assign w_oor_xfer = w_xfer && !w_bcast && !w_sel_in_range;

    // Lane write decode: one-hot on a unicast transfer, all lanes on a broadcast.
    always_comb begin
        w_wr_en = {NUM_OUTPUTS{1'b0}};
        for (int k = 0; k < NUM_OUTPUTS; k++) begin
            w_wr_en[k] = w_xfer && (w_bcast || (w_sel_in_range && (in_sel == SEL_WIDTH'(k))));
        end
    end

    // Dropped-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_oor_count <= {OOR_COUNT_WIDTH{1'b0}};
        end else if (w_oor_xfer) begin
            r_oor_count <= sat_inc(r_oor_count);
        end else begin
            r_oor_count <= r_oor_count;
        end
    end

    assign oor_count = r_oor_count;

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_lane
        demux_slot #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .i_wr_en      (w_wr_en[g]),
            .i_wr_data    (in_data),
            .i_rd_ready   (out_ready[g]),
            .o_valid      (out_valid[g]),
            .o_data       (out_data[g]),
            .o_can_accept (w_can_accept[g])
        );
    end

endmodule

// File: tb/tb_demux_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_stream
// Self-checking bench for demux_stream. A 32-lane instance is tracked by a
// lane-occupancy model; a 6-lane instance exercises out-of-range dropping and
// counter saturation. Broadcast scenarios compile only with DEMUX_BROADCAST_EN.
// -----------------------------------------------------------------------------
module tb_demux_stream;

    logic        clk;
    logic        rst;

    // 32-lane instance
    logic [31:0] in_data;
    logic [4:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic        bcast;
    logic [31:0] out_data [32];
    logic [31:0] out_valid;
    logic [31:0] out_ready;
    logic [15:0] oor_count;

    // 6-lane instance
    logic [31:0] in_data6;
    logic [2:0]  in_sel6;
    logic        in_valid6;
    logic        in_ready6;
    logic [31:0] out_data6 [6];
    logic [5:0]  out_valid6;
    logic [5:0]  out_ready6;
    logic [15:0] oor_count6;

    // Reference model of the 32-lane instance
    logic [31:0] exp_valid;
    logic [31:0] exp_data [32];

    int n_checks = 0;
    int n_fail   = 0;

    demux_stream #(.DATA_WIDTH(32), .NUM_OUTPUTS(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef DEMUX_BROADCAST_EN
        .in_bcast  (bcast),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .oor_count (oor_count)
    );

    demux_stream #(.DATA_WIDTH(32), .NUM_OUTPUTS(6)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data6),
        .in_sel    (in_sel6),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
`ifdef DEMUX_BROADCAST_EN
        .in_bcast  (1'b0),
`endif
        .out_data  (out_data6),
        .out_valid (out_valid6),
        .out_ready (out_ready6),
        .oor_count (oor_count6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Acceptance rule: a unicast beat goes in when its lane is empty or draining;
    // a broadcast needs every lane empty or draining.
    function automatic logic model_ready();
        logic r;
        if (bcast) begin
            r = 1'b1;
            for (int k = 0; k < 32; k++) r = r & (!exp_valid[k] || out_ready[k]);
        end else begin
            r = !exp_valid[in_sel] || out_ready[in_sel];
        end
        return r;
    endfunction

    // Advance one clock (inputs held since the falling edge) and update the model.
    task automatic tick();
        logic go;
        go = in_valid && model_ready();
        @(posedge clk);
        if (rst) begin
            exp_valid = 32'h0;
            for (int k = 0; k < 32; k++) exp_data[k] = 32'h0;
        end else begin
            exp_valid = exp_valid & ~out_ready;
            if (go) begin
                for (int k = 0; k < 32; k++) begin
                    if (bcast || (in_sel == k)) begin
                        exp_valid[k] = 1'b1;
                        exp_data[k]  = in_data;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_valid: got %h expected %h", out_valid, 32'h0);
        end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (out_data[k] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_data lane %0d: got %h expected 0", k, out_data[k]);
            end
        end
        n_checks++;
        if (oor_count !== 16'h0 || oor_count6 !== 16'h0 || out_valid6 !== 6'h0) begin
            n_fail++;
            $display("FAIL reset_oor: got %h/%h valid6 %b expected 0", oor_count, oor_count6, out_valid6);
        end
        out_ready = 32'h0;
        for (int s = 0; s < 32; s += 5) begin
            in_sel = 5'(s);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_in_ready sel %0d: got %b expected 1", s, in_ready);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        out_ready = 32'hFFFF_FFFF;
        in_sel    = 5'd5;
        in_data   = 32'hA5A5_0005;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        n_checks++;
        if (out_valid !== 32'h0000_0020 || out_data[5] !== 32'hA5A5_0005) begin
            n_fail++;
            $display("FAIL single_beat: got valid %h data %h expected 00000020 a5a50005", out_valid, out_data[5]);
        end
        tick();
        n_checks++;
        if (out_valid !== 32'h0 || out_data[5] !== 32'hA5A5_0005) begin
            n_fail++;
            $display("FAIL single_drain: got valid %h data %h expected 0 a5a50005", out_valid, out_data[5]);
        end
    endtask

    task automatic test_backpressure();
        out_ready    = 32'hFFFF_FFFF;
        out_ready[3] = 1'b0;
        in_sel       = 5'd3;
        in_data      = 32'hB000_0001;
        in_valid     = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_ready: got %b expected 1", in_ready);
        end
        tick();
        in_data = 32'hB000_0002;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (in_ready !== 1'b0 || out_valid[3] !== 1'b1 || out_data[3] !== 32'hB000_0001) begin
                n_fail++;
                $display("FAIL bp_stall cycle %0d: got ready %b valid %b data %h expected 0 1 b0000001",
                         c, in_ready, out_valid[3], out_data[3]);
            end
            tick();
        end
        out_ready[3] = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid[3] !== 1'b1 || out_data[3] !== 32'hB000_0002) begin
            n_fail++;
            $display("FAIL bp_second: got valid %b data %h expected 1 b0000002", out_valid[3], out_data[3]);
        end
        tick();
        n_checks++;
        if (out_valid !== 32'h0) begin
            n_fail++;
            $display("FAIL bp_drained: got %h expected 0", out_valid);
        end
    endtask

    task automatic test_lane_independence();
        int lanes [8] = '{0, 1, 4, 5, 6, 7, 8, 9};
        out_ready    = 32'hFFFF_FFFF;
        out_ready[2] = 1'b0;
        in_sel       = 5'd2;
        in_data      = 32'h2222_0002;
        in_valid     = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            in_sel  = 5'(lanes[i]);
            in_data = 32'hC000_0000 | 32'(lanes[i]);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL indep_ready lane %0d: got %b expected 1", lanes[i], in_ready);
            end
            tick();
            n_checks++;
            if (out_valid[lanes[i]] !== 1'b1 || out_data[lanes[i]] !== (32'hC000_0000 | 32'(lanes[i]))
                || out_valid[2] !== 1'b1 || out_data[2] !== 32'h2222_0002) begin
                n_fail++;
                $display("FAIL indep_lane %0d: got %b/%h lane2 %b/%h", lanes[i],
                         out_valid[lanes[i]], out_data[lanes[i]], out_valid[2], out_data[2]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 32'hFFFF_FFFF;
        tick();
        n_checks++;
        if (out_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL indep_final: got %h expected %h", out_valid, exp_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            out_ready = $urandom & $urandom;
            if (c % 3 == 0) out_ready = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 5'($urandom_range(0, 31));
            in_data   = $urandom;
`ifdef DEMUX_BROADCAST_EN
            bcast     = ($urandom_range(0, 15) == 0);
`endif
            #1;
            n_checks++;
            if (in_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL rand_ready cycle %0d: got %b expected %b", c, in_ready, model_ready());
            end
            tick();
            n_checks++;
            if (out_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL rand_valid cycle %0d: got %h expected %h", c, out_valid, exp_valid);
            end
            for (int k = 0; k < 32; k++) begin
                if (out_data[k] !== exp_data[k]) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rand_data cycle %0d lane %0d: got %h expected %h", c, k, out_data[k], exp_data[k]);
                end
            end
        end
        in_valid  = 1'b0;
        bcast     = 1'b0;
        out_ready = 32'hFFFF_FFFF;
        tick();
    endtask

    task automatic test_out_of_range();
        logic [2:0] sels [3] = '{3'd6, 3'd7, 3'd7};
        int         total;
        out_ready6 = 6'h3F;
        in_sel6    = 3'd2;
        in_data6   = 32'h6666_0002;
        in_valid6  = 1'b1;
        tick();
        n_checks++;
        if (out_valid6 !== 6'b000100 || out_data6[2] !== 32'h6666_0002) begin
            n_fail++;
            $display("FAIL oor_inrange: got %b %h expected 000100 66660002", out_valid6, out_data6[2]);
        end
        for (int i = 0; i < 3; i++) begin
            in_sel6  = sels[i];
            in_data6 = 32'hDEAD_0000 | 32'(i);
            #1;
            n_checks++;
            if (in_ready6 !== 1'b1) begin
                n_fail++;
                $display("FAIL oor_ready sel %0d: got %b expected 1", sels[i], in_ready6);
            end
            tick();
        end
        n_checks++;
        if (oor_count6 !== 16'd3 || out_valid6 !== 6'h0 || out_data6[2] !== 32'h6666_0002) begin
            n_fail++;
            $display("FAIL oor_count: got %0d valid %b expected 3 000000", oor_count6, out_valid6);
        end
        // Drive the counter right up to and past its ceiling.
        total = 3;
        in_sel6 = 3'd7;
        for (int i = 0; i < 65531; i++) tick();
        total += 65531;
        n_checks++;
        if (oor_count6 !== 16'(total)) begin
            n_fail++;
            $display("FAIL oor_near_max: got %h expected %h", oor_count6, 16'(total));
        end
        for (int i = 0; i < 4; i++) tick();
        total += 4;
        in_valid6 = 1'b0;
        n_checks++;
        if (oor_count6 !== ((total > 65535) ? 16'hFFFF : 16'(total))) begin
            n_fail++;
            $display("FAIL oor_saturate: got %h expected ffff", oor_count6);
        end
    endtask

    task automatic test_mid_reset();
        out_ready = 32'h0;
        in_valid  = 1'b1;
        in_sel    = 5'd0;
        in_data   = 32'h0000_F000;
        tick();
        in_sel    = 5'd4;
        in_data   = 32'h0000_F004;
        tick();
        n_checks++;
        if (out_valid !== 32'h0000_0011) begin
            n_fail++;
            $display("FAIL mid_prefill: got %h expected 00000011", out_valid);
        end
        in_sel  = 5'd6;
        in_data = 32'h0000_F006;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 32'h0 || oor_count !== 16'h0 || oor_count6 !== 16'h0 || out_data[6] !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: got valid %h oor %h/%h data6 %h expected all 0",
                     out_valid, oor_count, oor_count6, out_data[6]);
        end
        tick();
        n_checks++;
        if (out_valid !== exp_valid || out_valid[6] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_nodeliver: got %h expected %h", out_valid, exp_valid);
        end
    endtask

`ifdef DEMUX_BROADCAST_EN
    task automatic test_broadcast();
        out_ready    = 32'hFFFF_FFFF;
        out_ready[1] = 1'b0;
        in_sel       = 5'd1;
        in_data      = 32'h1111_0001;
        in_valid     = 1'b1;
        tick();
        bcast   = 1'b1;
        in_sel  = 5'd9;
        in_data = 32'hBCBC_BCBC;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bcast_blocked: got %b expected 0", in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 32'h0000_0002 || out_data[1] !== 32'h1111_0001) begin
            n_fail++;
            $display("FAIL bcast_hold: got %h %h expected 00000002 11110001", out_valid, out_data[1]);
        end
        out_ready[1] = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bcast_release: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        bcast    = 1'b0;
        n_checks++;
        if (out_valid !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL bcast_valid: got %h expected ffffffff", out_valid);
        end
        for (int k = 0; k < 32; k++) begin
            n_checks++;
            if (out_data[k] !== 32'hBCBC_BCBC) begin
                n_fail++;
                $display("FAIL bcast_data lane %0d: got %h expected bcbcbcbc", k, out_data[k]);
            end
        end
        tick();
    endtask
`endif

    initial begin
        rst        = 1'b1;
        in_data    = 32'h0;
        in_sel     = 5'd0;
        in_valid   = 1'b0;
        bcast      = 1'b0;
        out_ready  = 32'hFFFF_FFFF;
        in_data6   = 32'h0;
        in_sel6    = 3'd0;
        in_valid6  = 1'b0;
        out_ready6 = 6'h3F;
        exp_valid  = 32'h0;
        for (int k = 0; k < 32; k++) exp_data[k] = 32'h0;
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_backpressure();
        test_lane_independence();
        test_random();
        test_out_of_range();
        test_mid_reset();
`ifdef DEMUX_BROADCAST_EN
        test_broadcast();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
